// File: rtl/video_argmax_top2_if.sv
// Stream interfaces for video_argmax_top2: packed class scores in, classification result out.
// Handshake: a beat transfers on a rising aclk edge where tvalid & tready are both 1;
// the source holds every field stable while tvalid & ~tready.
interface video_argmax_top2_s_if #(
    parameter int CLASS_NUM   = 11,
    parameter int CLASS_WIDTH = 8,
    parameter int TDATA_WIDTH = 10,
    parameter int TUSER_WIDTH = 1
);
    logic [TUSER_WIDTH-1:0]           tuser;
    logic                             tlast;
    logic [TDATA_WIDTH-1:0]           tdata;
    logic [CLASS_NUM*CLASS_WIDTH-1:0] tclass;
    logic                             tvalid;
    logic                             tready;

    modport master (output tuser, tlast, tdata, tclass, tvalid, input tready);
    modport slave  (input tuser, tlast, tdata, tclass, tvalid, output tready);
endinterface

interface video_argmax_top2_m_if #(
    parameter int CLASS_WIDTH  = 8,
    parameter int ARGMAX_WIDTH = 8,
    parameter int TDATA_WIDTH  = 10,
    parameter int TUSER_WIDTH  = 1
);
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tlast;
    logic [TDATA_WIDTH-1:0]  tdata;
    logic [ARGMAX_WIDTH-1:0] targmax;
    logic [CLASS_WIDTH-1:0]  tmax;
    logic [CLASS_WIDTH:0]    tmargin;
    logic                    tconfident;
    logic                    tvalid;
    logic                    tready;

    modport master (output tuser, tlast, tdata, targmax, tmax, tmargin, tconfident, tvalid,
                    input tready);
    modport slave  (input tuser, tlast, tdata, targmax, tmax, tmargin, tconfident, tvalid,
                    output tready);
endinterface

// File: rtl/video_argmax_top2.sv
// Pipelined per-pixel top-1/top-2 classifier head: registered tournament tree plus margin stage.
// Optional confidence gating is enabled by defining VIDEO_ARGMAX_TOP2_THRESHOLD_EN.
module video_argmax_top2 #(
    parameter int CLASS_NUM     = 11,
    parameter int CLASS_WIDTH   = 8,
    parameter bit DATA_SIGNED   = 1'b0,
    parameter int ARGMAX_WIDTH  = 8,
    parameter int UNKNOWN_INDEX = CLASS_NUM,
    parameter int TDATA_WIDTH   = 10,
    parameter int TUSER_WIDTH   = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [CLASS_WIDTH-1:0] s_threshold,
    video_argmax_top2_s_if.slave   s_axi4s,
    video_argmax_top2_m_if.master  m_axi4s
);
    localparam int LEVELS = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 0;
    localparam int LEAVES = 1 << LEVELS;
    localparam int IDX_W  = (LEVELS > 0) ? LEVELS : 1;
    localparam int CW     = CLASS_WIDTH;
    localparam logic [CW-1:0] SCORE_MIN = DATA_SIGNED ? (CW'(1) << (CW - 1)) : '0;

    function automatic logic gt(input logic [CW-1:0] a, input logic [CW-1:0] b);
        if (DATA_SIGNED) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // The whole pipeline moves as one; a stalled output freezes every stage.
    logic cke;
    logic out_vld;
    assign cke            = m_axi4s.tready | ~out_vld;
    assign s_axi4s.tready = cke;

    logic [LEAVES*CW-1:0] padded;
    logic [CW-1:0]        leaf_max [LEAVES];
    logic [IDX_W-1:0]     leaf_idx [LEAVES];

    always_comb begin
        padded = {LEAVES{SCORE_MIN}};
        padded[CLASS_NUM*CW-1:0] = s_axi4s.tclass;
        for (int n = 0; n < LEAVES; n++) begin
            leaf_max[n] = padded[n*CW +: CW];
            leaf_idx[n] = IDX_W'(n);
        end
    end

    logic [CW-1:0]    root_max;
    logic [CW-1:0]    root_sec;
    logic [IDX_W-1:0] root_idx;

    if (LEVELS > 0) begin : g_tree
        // Internal nodes of level l live at offset LEAVES - 2*(LEAVES>>l); the root is last.
        localparam int NODES = LEAVES - 1;
        logic [CW-1:0]    max_d [NODES], max_q [NODES];
        logic [CW-1:0]    sec_d [NODES], sec_q [NODES];
        logic [IDX_W-1:0] idx_d [NODES], idx_q [NODES];

        always_comb begin
            logic [CW-1:0]    a_max, a_sec, b_max, b_sec, lose, wsec;
            logic [IDX_W-1:0] a_idx, b_idx;
            logic             b_win;
            int               src, dst;
            max_d = max_q;
            sec_d = sec_q;
            idx_d = idx_q;
            a_max = '0; a_sec = '0; b_max = '0; b_sec = '0; lose = '0; wsec = '0;
            a_idx = '0; b_idx = '0; b_win = 1'b0; src = 0; dst = 0;
            for (int l = 1; l <= LEVELS; l++) begin
                for (int n = 0; n < (LEAVES >> l); n++) begin
                    if (l == 1) begin
                        a_max = leaf_max[2*n];   a_idx = leaf_idx[2*n];   a_sec = SCORE_MIN;
                        b_max = leaf_max[2*n+1]; b_idx = leaf_idx[2*n+1]; b_sec = SCORE_MIN;
                    end else begin
                        src   = LEAVES - 2 * (LEAVES >> (l - 1)) + 2 * n;
                        a_max = max_q[src];   a_idx = idx_q[src];   a_sec = sec_q[src];
                        b_max = max_q[src+1]; b_idx = idx_q[src+1]; b_sec = sec_q[src+1];
                    end
                    // Ties keep the lower-index side.
                    b_win      = gt(b_max, a_max);
                    lose       = b_win ? a_max : b_max;
                    wsec       = b_win ? b_sec : a_sec;
                    dst        = LEAVES - 2 * (LEAVES >> l) + n;
                    max_d[dst] = b_win ? b_max : a_max;
                    idx_d[dst] = b_win ? b_idx : a_idx;
                    sec_d[dst] = gt(lose, wsec) ? lose : wsec;
                end
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                for (int i = 0; i < NODES; i++) begin
                    max_q[i] <= '0;
                    sec_q[i] <= '0;
                    idx_q[i] <= '0;
                end
            end else if (cke) begin
                max_q <= max_d;
                sec_q <= sec_d;
                idx_q <= idx_d;
            end
        end

        assign root_max = max_q[NODES-1];
        assign root_sec = sec_q[NODES-1];
        assign root_idx = idx_q[NODES-1];
    end else begin : g_single
        assign root_max = leaf_max[0];
        assign root_sec = SCORE_MIN;
        assign root_idx = leaf_idx[0];
    end

    // Stage s of the sideband lines up with tree level s+1; stage LEVELS is the output stage.
    logic                   vld_d  [LEVELS+1], vld_q  [LEVELS+1];
    logic                   last_d [LEVELS+1], last_q [LEVELS+1];
    logic [TUSER_WIDTH-1:0] user_d [LEVELS+1], user_q [LEVELS+1];
    logic [TDATA_WIDTH-1:0] data_d [LEVELS+1], data_q [LEVELS+1];

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        user_d = user_q;
        data_d = data_q;
        vld_d[0]  = s_axi4s.tvalid;
        last_d[0] = s_axi4s.tlast;
        user_d[0] = s_axi4s.tuser;
        data_d[0] = s_axi4s.tdata;
        for (int s = 1; s <= LEVELS; s++) begin
            vld_d[s]  = vld_q[s-1];
            last_d[s] = last_q[s-1];
            user_d[s] = user_q[s-1];
            data_d[s] = data_q[s-1];
        end
    end

    logic [CW:0]             margin;
    logic [CW-1:0]           tmax_d, tmax_q;
    logic [CW:0]             tmargin_d, tmargin_q;
    logic [ARGMAX_WIDTH-1:0] targmax_d, targmax_q;

    always_comb begin
        // Sign- or zero-extend by one bit so top-1 minus top-2 never wraps.
        margin    = {DATA_SIGNED & root_max[CW-1], root_max}
                  - {DATA_SIGNED & root_sec[CW-1], root_sec};
        tmax_d    = root_max;
        tmargin_d = margin;
`ifdef VIDEO_ARGMAX_TOP2_THRESHOLD_EN
        targmax_d = (margin >= {1'b0, s_threshold}) ? ARGMAX_WIDTH'(root_idx)
                                                     : ARGMAX_WIDTH'(UNKNOWN_INDEX);
`else
        targmax_d = ARGMAX_WIDTH'(root_idx);
`endif
    end

`ifdef VIDEO_ARGMAX_TOP2_THRESHOLD_EN
    logic conf_d, conf_q;
    assign conf_d = (margin >= {1'b0, s_threshold});

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  conf_q <= 1'b0;
        else if (cke)  conf_q <= conf_d;
    end
    assign m_axi4s.tconfident = conf_q;
`else
    logic unused_cfg;
    assign unused_cfg         = ^{s_threshold, ARGMAX_WIDTH'(UNKNOWN_INDEX)};
    assign m_axi4s.tconfident = 1'b1;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int s = 0; s <= LEVELS; s++) begin
                vld_q[s]  <= 1'b0;
                last_q[s] <= 1'b0;
                user_q[s] <= '0;
                data_q[s] <= '0;
            end
            tmax_q    <= '0;
            tmargin_q <= '0;
            targmax_q <= '0;
        end else if (cke) begin
            vld_q     <= vld_d;
            last_q    <= last_d;
            user_q    <= user_d;
            data_q    <= data_d;
            tmax_q    <= tmax_d;
            tmargin_q <= tmargin_d;
            targmax_q <= targmax_d;
        end
    end

    assign out_vld           = vld_q[LEVELS];
    assign m_axi4s.tvalid    = out_vld;
    assign m_axi4s.tuser     = user_q[LEVELS];
    assign m_axi4s.tlast     = last_q[LEVELS];
    assign m_axi4s.tdata     = data_q[LEVELS];
    assign m_axi4s.tmax      = tmax_q;
    assign m_axi4s.tmargin   = tmargin_q;
    assign m_axi4s.targmax   = targmax_q;
endmodule

// File: tb/tb_video_argmax_top2.sv
// Directed-vector bench for video_argmax_top2: 11-class unsigned, 11-class signed and
// single-class instances, with a scoreboard queue on the main instance.
`timescale 1ns/1ps
module tb_video_argmax_top2;
`ifdef VIDEO_ARGMAX_TOP2_THRESHOLD_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] thr;
    always #5 clk = ~clk;

    video_argmax_top2_s_if #(.CLASS_NUM(11), .CLASS_WIDTH(8), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) s_if ();
    video_argmax_top2_m_if #(.CLASS_WIDTH(8), .ARGMAX_WIDTH(8), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) m_if ();
    video_argmax_top2_s_if #(.CLASS_NUM(11), .CLASS_WIDTH(8), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) sg_s ();
    video_argmax_top2_m_if #(.CLASS_WIDTH(8), .ARGMAX_WIDTH(8), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) sg_m ();
    video_argmax_top2_s_if #(.CLASS_NUM(1), .CLASS_WIDTH(8), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) one_s ();
    video_argmax_top2_m_if #(.CLASS_WIDTH(8), .ARGMAX_WIDTH(8), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) one_m ();

    video_argmax_top2 #(.CLASS_NUM(11), .CLASS_WIDTH(8), .DATA_SIGNED(1'b0), .ARGMAX_WIDTH(8),
                        .UNKNOWN_INDEX(11), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) dut (
        .aclk(clk), .aresetn(rst_n), .s_threshold(thr), .s_axi4s(s_if), .m_axi4s(m_if));
    video_argmax_top2 #(.CLASS_NUM(11), .CLASS_WIDTH(8), .DATA_SIGNED(1'b1), .ARGMAX_WIDTH(8),
                        .UNKNOWN_INDEX(11), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) dut_sg (
        .aclk(clk), .aresetn(rst_n), .s_threshold(thr), .s_axi4s(sg_s), .m_axi4s(sg_m));
    video_argmax_top2 #(.CLASS_NUM(1), .CLASS_WIDTH(8), .DATA_SIGNED(1'b0), .ARGMAX_WIDTH(8),
                        .UNKNOWN_INDEX(1), .TDATA_WIDTH(10), .TUSER_WIDTH(1)) dut_one (
        .aclk(clk), .aresetn(rst_n), .s_threshold(thr), .s_axi4s(one_s), .m_axi4s(one_m));

    // ---------------- directed vectors (hand-computed results) ----------------
    int vec_sc [0:6][0:10] = '{
        '{10, 10, 10, 200, 10, 10, 10, 150, 10, 10, 10},
        '{0, 0, 90, 0, 0, 90, 0, 0, 0, 90, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 255},
        '{100, 80, 5, 5, 5, 5, 5, 5, 5, 5, 5},
        '{30, 30, 30, 30, 31, 30, 50, 30, 30, 30, 30},
        '{0, 20, 40, 60, 80, 100, 120, 140, 160, 180, 200}
    };
    int vec_idx [0:6] = '{3, 2, 0, 10, 0, 6, 10};
    int vec_max [0:6] = '{200, 90, 0, 255, 100, 50, 200};
    int vec_mar [0:6] = '{50, 0, 0, 255, 20, 19, 20};

    // ---------------- scoreboard ----------------
    logic [37:0] exp_q [$];
    int errors = 0;
    int checks = 0;
    int ready_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [87:0] pack_vec(input int v);
        logic [87:0] p;
        p = '0;
        for (int n = 0; n < 11; n++) p[n*8 +: 8] = 8'(vec_sc[v][n]);
        return p;
    endfunction

    function automatic logic [37:0] make_exp(input logic user, input logic last, input logic [9:0] data,
                                             input int idx, input int mx, input int mar,
                                             input int th, input int unk);
        logic       conf;
        logic [7:0] am;
        conf = (mar >= th);
        am   = (THR_EN && !conf) ? 8'(unk) : 8'(idx);
        if (!THR_EN) conf = 1'b1;
        return {user, last, data, am, 8'(mx), 9'(mar), conf};
    endfunction

    function automatic logic [37:0] got_main();
        return {m_if.tuser, m_if.tlast, m_if.tdata, m_if.targmax, m_if.tmax, m_if.tmargin, m_if.tconfident};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_beat(input int v, input logic user, input logic last, input logic [9:0] data);
        int n;
        s_if.tclass = pack_vec(v);
        s_if.tuser  = user;
        s_if.tlast  = last;
        s_if.tdata  = data;
        s_if.tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s_if.tready !== 1'b1 && n < 200);
        if (s_if.tready !== 1'b1) check("accept_timeout", 64'd0, 64'd1);
        else exp_q.push_back(make_exp(user, last, data, vec_idx[v], vec_max[v], vec_mar[v], int'(thr), 11));
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid === 1'b1) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_sg(input logic [87:0] cls, input int idx, input int mx, input int mar);
        sg_s.tclass = cls;
        sg_s.tuser  = 1'b0;
        sg_s.tlast  = 1'b1;
        sg_s.tdata  = 10'h2A;
        sg_s.tvalid = 1'b1;
        @(posedge clk);
        #1;
        sg_s.tvalid = 1'b0;
        repeat (4) @(negedge clk);
        check("sg_early", 64'(sg_m.tvalid), 64'd0);
        @(negedge clk);
        check("sg_vld", 64'(sg_m.tvalid), 64'd1);
        check("sg_beat", 64'({sg_m.tuser, sg_m.tlast, sg_m.tdata, sg_m.targmax, sg_m.tmax,
                              sg_m.tmargin, sg_m.tconfident}),
              64'(make_exp(1'b0, 1'b1, 10'h2A, idx, mx, mar, int'(thr), 11)));
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [7:0] sc, input int mar);
        one_s.tclass = sc;
        one_s.tuser  = 1'b1;
        one_s.tlast  = 1'b0;
        one_s.tdata  = 10'h3C1;
        one_s.tvalid = 1'b1;
        @(posedge clk);
        #1;
        one_s.tvalid = 1'b0;
        @(negedge clk);
        check("one_vld", 64'(one_m.tvalid), 64'd1);
        check("one_beat", 64'({one_m.tuser, one_m.tlast, one_m.tdata, one_m.targmax, one_m.tmax,
                               one_m.tmargin, one_m.tconfident}),
              64'(make_exp(1'b1, 1'b0, 10'h3C1, 0, int'(sc), mar, int'(thr), 1)));
        @(posedge clk);
        #1;
    endtask

    // ---------------- output ready and monitor ----------------
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1)      m_if.tready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) m_if.tready = 1'b0;
            else                      m_if.tready = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && m_if.tvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("beat", 64'(got_main()), 64'(exp_q[0]));
                    if (m_if.tready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        check("watchdog", 64'd0, 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int stale;
        logic [87:0] cls;
        rst_n = 1'b0;
        thr   = 8'd20;
        s_if.tclass = '0;  s_if.tuser = '0;  s_if.tlast = 1'b0;  s_if.tdata = '0;  s_if.tvalid = 1'b0;
        sg_s.tclass = '0;  sg_s.tuser = '0;  sg_s.tlast = 1'b0;  sg_s.tdata = '0;  sg_s.tvalid = 1'b0;
        one_s.tclass = '0; one_s.tuser = '0; one_s.tlast = 1'b0; one_s.tdata = '0; one_s.tvalid = 1'b0;
        sg_m.tready  = 1'b1;
        one_m.tready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tready", 64'(s_if.tready), 64'd1);
        check("rst_out", 64'(got_main()), 64'(!THR_EN));
        check("rst_sg_tvalid", 64'(sg_m.tvalid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and basic result
        drive_beat(0, 1'b1, 1'b0, 10'h155);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (m_if.tvalid !== 1'b1 && lat < 50);
        check("latency", 64'(lat), 64'd5);
        wait_drain(50);

        // Threshold boundary on an all-tie pixel
        thr = 8'd0;
        drive_beat(1, 1'b0, 1'b0, 10'h001);
        wait_drain(50);
        thr = 8'd1;
        drive_beat(1, 1'b0, 1'b1, 10'h002);
        wait_drain(50);

        // All vectors back to back
        thr = 8'd20;
        for (int v = 0; v < 7; v++) drive_beat(v, 1'(v == 0), 1'(v == 6), 10'(v * 37));
        wait_drain(50);

        // Signed scores
        cls = {11{8'h80}};
        cls[80 +: 8] = 8'hFF;
        run_sg(cls, 10, 255, 127);
        cls = {11{8'h80}};
        cls[0 +: 8] = 8'd5;
        cls[8 +: 8] = 8'hFD;
        run_sg(cls, 0, 5, 8);

        // Single class
        run_one(8'd77, 77);
        run_one(8'd5, 5);

        // Random valid/ready over many beats
        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            drive_beat(int'($urandom_range(0, 6)), 1'(i % 64 == 0), 1'(i % 64 == 63),
                       10'($urandom_range(0, 1023)));
        end
        wait_drain(3000);
        ready_mode = 0;

        // Reset with beats in flight and the output stalled
        ready_mode = 2;
        @(posedge clk);
        #1;
        drive_beat(3, 1'b0, 1'b0, 10'h011);
        drive_beat(4, 1'b0, 1'b0, 10'h022);
        drive_beat(5, 1'b0, 1'b1, 10'h033);
        lat = 0;
        while (m_if.tvalid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("stall_vld", 64'(m_if.tvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("arst_tready", 64'(s_if.tready), 64'd1);
        check("arst_out", 64'(got_main()), 64'(!THR_EN));
        ready_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_if.tvalid === 1'b1) stale++;
        end
        check("post_rst_beats", 64'(stale), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
